bram_arbiter: RTL

- Shares one simple dual-port block RAM (write port + read port, registered read on the falling edge) among numReq_p requesters.
- Arbitrates write and read ports independently with round-robin; one write and one read can be issued per cycle.
- Registers commands onto the RAM and routes returned read data back to the originating requester.
- Sits between CPU/DMA/peripheral masters and a bram instance in the top level.

---
 rtl/bram_pkg.sv | 28 ++
 rtl/bram_arbiter_rr_pick.sv | 57 +++++
 rtl/bram_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bram_pkg
//  Purpose  : Shared constants and helpers for the block-RAM arbiter.
//             MAX_REQ bounds the requester count, IDX_W is the width of a
//             requester index, onehot() expands an index into a MAX_REQ-wide
//             one-hot vector, slice_lo() gives the low bit of slice k on a
//             flattened per-requester bus.
//  Revision : 1.0 - initial release
// ============================================================================
package bram_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int slice_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin selector. Scans requesters starting
//             at the pointer, wrapping modulo numReq_p, and picks the first
//             one with its request bit set.
//  Ports    : i_req   - request vector
//             i_ptr   - highest-priority requester index (0..numReq_p-1)
//             o_gnt   - one-hot grant (all zero when nobody requests)
//             o_idx   - index of the granted requester
//             o_valid - a grant was issued
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import bram_pkg::*;
#(
  parameter int numReq_p = 2
) (
  input  logic [numReq_p-1:0] i_req,
  input  logic [IDX_W-1:0]    i_ptr,
  output logic [numReq_p-1:0] o_gnt,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_valid
);

  localparam logic [IDX_W:0] c_num = (IDX_W+1)'(numReq_p);

  // Padding to MAX_REQ lets the candidate index address the vector without
  // any width mismatch, whatever numReq_p is.
  logic [MAX_REQ-1:0] w_req_pad;
  logic [IDX_W:0]     w_cand;
  logic               w_found;

  always_comb begin
    w_req_pad                 = '0;
    w_req_pad[numReq_p-1:0]   = i_req;
    w_found                   = 1'b0;
    w_cand                    = '0;
    o_idx                     = '0;
    for (int i = 0; i < numReq_p; i++) begin
      // ptr < numReq_p and i < numReq_p, so one subtraction completes the wrap
      w_cand = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_cand >= c_num) begin
        w_cand = w_cand - c_num;
      end
      if (!w_found && w_req_pad[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        o_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

  assign o_gnt   = w_found ? numReq_p'(onehot(o_idx)) : '0;
  assign o_valid = w_found;

endmodule
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bram_arbiter
//  Purpose  : Shares one simple dual-port block RAM (write port + read port,
//             read registered on the falling edge) among numReq_p requesters.
//             Write and read ports are arbitrated independently with
//             round-robin; one write and one read may be issued per cycle.
//             Returned read data is routed back with a one-hot rvalid pulse.
//  Ports    : clk_i, rst_ni          - clock, async active-low reset
//             wreq_i/waddr_i/wdata_i - per-requester write request buses
//             wgnt_o                 - one-hot write grant (combinational)
//             rreq_i/raddr_i         - per-requester read request buses
//             rgnt_o                 - one-hot read grant (combinational)
//             rvalid_o/rdata_o       - read return, one-hot valid + shared data
//             mem_*                  - registered command to / data from RAM
//  Revision : 1.0 - initial release
// ============================================================================
module bram_arbiter
  import bram_pkg::*;
#(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16,
  parameter int numReq_p    = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [numReq_p-1:0]             wreq_i,
  input  logic [numReq_p*memSize_p-1:0]   waddr_i,
  input  logic [numReq_p*dataWidth_p-1:0] wdata_i,
  output logic [numReq_p-1:0]             wgnt_o,
  input  logic [numReq_p-1:0]             rreq_i,
  input  logic [numReq_p*memSize_p-1:0]   raddr_i,
  output logic [numReq_p-1:0]             rgnt_o,
  output logic [numReq_p-1:0]             rvalid_o,
  output logic [dataWidth_p-1:0]          rdata_o,
  output logic                            mem_write_o,
  output logic [memSize_p-1:0]            mem_waddr_o,
  output logic [dataWidth_p-1:0]          mem_wdata_o,
  output logic                            mem_read_o,
  output logic [memSize_p-1:0]            mem_raddr_o,
  input  logic [dataWidth_p-1:0]          mem_rdata_i
);

  localparam logic [IDX_W-1:0] c_last = IDX_W'(numReq_p - 1);

  logic [IDX_W-1:0]       r_wptr, r_rptr;
  logic                   r_mem_write, r_mem_read;
  logic [memSize_p-1:0]   r_waddr, r_raddr;
  logic [dataWidth_p-1:0] r_wdata, r_rdata;
  logic [IDX_W-1:0]       r_rtag;
  logic [numReq_p-1:0]    r_rvalid;

  logic [numReq_p-1:0]    w_wgnt, w_rgnt;
  logic [IDX_W-1:0]       w_widx, w_ridx;
  logic                   w_wvld, w_rvld;
  logic [IDX_W-1:0]       w_wptr_nxt, w_rptr_nxt;
  logic [memSize_p-1:0]   w_waddr, w_raddr;
  logic [dataWidth_p-1:0] w_wdata;

  rr_pick #(.numReq_p(numReq_p)) u_wpick (
    .i_req   (wreq_i),
    .i_ptr   (r_wptr),
    .o_gnt   (w_wgnt),
    .o_idx   (w_widx),
    .o_valid (w_wvld)
  );

  rr_pick #(.numReq_p(numReq_p)) u_rpick (
    .i_req   (rreq_i),
    .i_ptr   (r_rptr),
    .o_gnt   (w_rgnt),
    .o_idx   (w_ridx),
    .o_valid (w_rvld)
  );

  // Grants are hidden while reset is held so no requester believes it was
  // accepted by a cycle that the registers will never capture.
  assign wgnt_o = rst_ni ? w_wgnt : '0;
  assign rgnt_o = rst_ni ? w_rgnt : '0;

  assign w_wptr_nxt = (w_widx == c_last) ? '0 : w_widx + IDX_W'(1);
  assign w_rptr_nxt = (w_ridx == c_last) ? '0 : w_ridx + IDX_W'(1);

  // Route the granted requester's address/data onto the command path.
  always_comb begin
    w_waddr = '0;
    w_wdata = '0;
    w_raddr = '0;
    for (int k = 0; k < numReq_p; k++) begin
      if (w_wgnt[k]) begin
        w_waddr = waddr_i[slice_lo(k, memSize_p)   +: memSize_p];
        w_wdata = wdata_i[slice_lo(k, dataWidth_p) +: dataWidth_p];
      end
      if (w_rgnt[k]) begin
        w_raddr = raddr_i[slice_lo(k, memSize_p) +: memSize_p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_raddr     <= '0;
      r_rtag      <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
    end else begin
      r_mem_write <= w_wvld;
      if (w_wvld) begin
        r_waddr <= w_waddr;
        r_wdata <= w_wdata;
        r_wptr  <= w_wptr_nxt;
      end

      // r_mem_read doubles as the valid bit of the read tag: the RAM samples
      // during the cycle it is high, and the data is captured one edge later.
      r_mem_read <= w_rvld;
      if (w_rvld) begin
        r_raddr <= w_raddr;
        r_rtag  <= w_ridx;
        r_rptr  <= w_rptr_nxt;
      end

      r_rvalid <= r_mem_read ? numReq_p'(onehot(r_rtag)) : '0;
      if (r_mem_read) begin
        r_rdata <= mem_rdata_i;
      end
    end
  end

  assign mem_write_o = r_mem_write;
  assign mem_waddr_o = r_waddr;
  assign mem_wdata_o = r_wdata;
  assign mem_read_o  = r_mem_read;
  assign mem_raddr_o = r_raddr;
  assign rvalid_o    = r_rvalid;
  assign rdata_o     = r_rdata;

endmodule
`default_nettype wire
